// File: rtl/zigbee_io_bridge.sv
// zigbee_io_bridge: core-side stage behind the pad ring.
// Synchronises the asynchronous pad buses, decodes sel into four tester
// modes and bridges tester strobe pulses to/from the Zigbee core through a
// TX FIFO and an RX FIFO.
//   clk_i, resetn_i        core clock, async active-low reset
//   sel_i[1:0]             tester mode select (async)
//   mux_i[21:0]            pad input: [7:0] data, [8] strobe, [9] clear
//   mux_o[17:0]            registered pad output (loopback / TX / RX / status)
//   tx_data_o/valid/ready  TX byte stream to the core
//   rx_data_i/valid/ready  RX byte stream from the core
//   status_i[15:0]         core status word, readable in STATUS mode
module zigbee_io_bridge #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [1:0]  sel_i,
  input  logic [21:0] mux_i,
  output logic [17:0] mux_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic [15:0] status_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    MODE_LOOPBACK = 2'b00,
    MODE_TX_LOAD  = 2'b01,
    MODE_RX_READ  = 2'b10,
    MODE_STATUS   = 2'b11
  } mode_e;

  // Pad synchronisers
  logic [SYNC_STAGES-1:0][1:0]  sel_sync_q;
  logic [SYNC_STAGES-1:0][21:0] in_sync_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      sel_sync_q <= '0;
      in_sync_q  <= '0;
    end else begin
      sel_sync_q[0] <= sel_i;
      in_sync_q[0]  <= mux_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sel_sync_q[i] <= sel_sync_q[i-1];
        in_sync_q[i]  <= in_sync_q[i-1];
      end
    end
  end

  mode_e       ssel;
  logic [21:0] sin;
  logic        unused_pad_bits;

  assign ssel            = mode_e'(sel_sync_q[SYNC_STAGES-1]);
  assign sin             = in_sync_q[SYNC_STAGES-1];
  assign unused_pad_bits = ^sin[21:18];

  // Edge detection; a mode change masks edges for that one cycle
  mode_e prev_sel_q;
  logic  prev_stb_q, prev_clr_q;
  logic  mode_chg, stb_edge, clr_edge;

  assign mode_chg = (ssel != prev_sel_q);
  assign stb_edge = sin[8] & ~prev_stb_q & ~mode_chg;
  assign clr_edge = sin[9] & ~prev_clr_q & ~mode_chg;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      prev_sel_q <= MODE_LOOPBACK;
      prev_stb_q <= 1'b0;
      prev_clr_q <= 1'b0;
    end else begin
      prev_sel_q <= ssel;
      prev_stb_q <= sin[8];
      prev_clr_q <= sin[9];
    end
  end

  // TX FIFO: tester pushes, core pops
  logic [7:0]    tx_mem_q [DEPTH];
  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_ovf_q, tx_ovf_d;
  logic          tx_empty, tx_full, tx_pop, tx_push_req, tx_push, tx_flush;

  assign tx_empty    = (tx_cnt_q == '0);
  assign tx_full     = (tx_cnt_q == FULL_CNT);
  assign tx_valid_o  = ~tx_empty;
  assign tx_data_o   = tx_mem_q[tx_rptr_q];
  assign tx_pop      = tx_valid_o & tx_ready_i;
  assign tx_push_req = (ssel == MODE_TX_LOAD) & stb_edge;
  assign tx_flush    = (ssel == MODE_TX_LOAD) & clr_edge;
  // A full FIFO still accepts a push when the core frees a slot this cycle
  assign tx_push     = tx_push_req & (~tx_full | tx_pop) & ~tx_flush;

  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    tx_ovf_d  = tx_ovf_q;
    if (tx_flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      tx_cnt_d  = '0;
      tx_ovf_d  = 1'b0;
    end else begin
      if (tx_push) tx_wptr_d = tx_wptr_q + AW'(1);
      if (tx_pop)  tx_rptr_d = tx_rptr_q + AW'(1);
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      if (tx_push_req & tx_full & ~tx_pop) tx_ovf_d = 1'b1;
    end
  end

  // RX FIFO: core pushes, tester pops
  logic [7:0]    rx_mem_q [DEPTH];
  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_ovf_q, rx_ovf_d;
  logic          rx_empty, rx_full, rx_push, rx_pop, rx_flush;
  logic [7:0]    rx_head;

  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_full    = (rx_cnt_q == FULL_CNT);
  assign rx_ready_o = ~rx_full;
  assign rx_head    = rx_mem_q[rx_rptr_q];
  assign rx_flush   = (ssel == MODE_RX_READ) & clr_edge;
  assign rx_push    = rx_valid_i & rx_ready_o & ~rx_flush;
  assign rx_pop     = (ssel == MODE_RX_READ) & stb_edge & ~rx_empty & ~rx_flush;

  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    rx_ovf_d  = rx_ovf_q;
    if (rx_flush) begin
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      rx_cnt_d  = '0;
      rx_ovf_d  = 1'b0;
    end else begin
      if (rx_push) rx_wptr_d = rx_wptr_q + AW'(1);
      if (rx_pop)  rx_rptr_d = rx_rptr_q + AW'(1);
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
      if (rx_valid_i & rx_full) rx_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      rx_ovf_q  <= 1'b0;
    end else begin
      if (tx_push) tx_mem_q[tx_wptr_q] <= sin[7:0];
      if (rx_push) rx_mem_q[rx_wptr_q] <= rx_data_i;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_ovf_q  <= rx_ovf_d;
    end
  end

  // Pad output register; views reflect FIFO state before this cycle's update
  logic [17:0] mux_q, mux_d;

  always_comb begin
    mux_d = '0;
    unique case (ssel)
      MODE_LOOPBACK: mux_d = sin[17:0];
      MODE_TX_LOAD:  mux_d = 18'({tx_ovf_q, tx_full, tx_empty, tx_cnt_q});
      MODE_RX_READ:  mux_d = 18'({rx_cnt_q, rx_ovf_q, ~rx_empty, rx_head});
      MODE_STATUS:   mux_d = {2'b00, status_i};
      default:       mux_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) mux_q <= '0;
    else           mux_q <= mux_d;
  end

  assign mux_o = mux_q;

endmodule

// File: tb/tb_zigbee_io_bridge.sv
// Self-checking bench for zigbee_io_bridge: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_zigbee_io_bridge;

  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        resetn_i;
  logic [1:0]  sel_i;
  logic [21:0] mux_i;
  logic [17:0] mux_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [15:0] status_i;

  always #5 clk = ~clk;

  zigbee_io_bridge #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk_i      (clk),
    .resetn_i   (resetn_i),
    .sel_i      (sel_i),
    .mux_i      (mux_i),
    .mux_o      (mux_o),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .rx_data_i  (rx_data_i),
    .rx_valid_i (rx_valid_i),
    .rx_ready_o (rx_ready_o),
    .status_i   (status_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pad values seen by the core are the ones sampled SYNC
  // edges earlier; FIFOs are plain queues.
  logic [21:0] hmux[$];
  logic [1:0]  hsel[$];
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic        tovf, rovf;
  logic [1:0]  m_psel;
  logic        m_p8, m_p9;
  logic [17:0] exp_mux, exp_mask;

  task automatic model_reset();
    txq.delete(); rxq.delete(); hmux.delete(); hsel.delete();
    for (int i = 0; i < SYNC; i++) begin
      hmux.push_back('0);
      hsel.push_back('0);
    end
    tovf = 1'b0; rovf = 1'b0;
    m_psel = '0; m_p8 = 1'b0; m_p9 = 1'b0;
    exp_mux = '0; exp_mask = '1;
  endtask

  task automatic model_edge();
    logic [21:0] sin;
    logic [1:0]  ss;
    logic        chg, stb, clr, rx_ok, rx_of;
    if (!resetn_i) begin
      exp_mux = '0; exp_mask = '1;
      return;
    end
    sin = hmux.pop_front();
    ss  = hsel.pop_front();
    hmux.push_back(mux_i);
    hsel.push_back(sel_i);
    chg = (ss != m_psel);
    stb = sin[8] && !m_p8 && !chg;
    clr = sin[9] && !m_p9 && !chg;
    exp_mask = '1;
    case (ss)
      2'd0: exp_mux = sin[17:0];
      2'd1: exp_mux = {12'b0, tovf, txq.size() == DEPTH, txq.size() == 0, 3'(txq.size())};
      2'd2: begin
        exp_mux = {5'b0, 3'(rxq.size()), rovf, rxq.size() != 0,
                   (rxq.size() != 0) ? rxq[0] : 8'h00};
        if (rxq.size() == 0) exp_mask = 18'h3FF00;
      end
      default: exp_mux = {2'b0, status_i};
    endcase
    // TX side
    if (ss == 2'd1 && clr) begin
      txq.delete(); tovf = 1'b0;
    end else begin
      if (txq.size() != 0 && tx_ready_i) void'(txq.pop_front());
      if (ss == 2'd1 && stb) begin
        if (txq.size() < DEPTH) txq.push_back(sin[7:0]);
        else tovf = 1'b1;
      end
    end
    // RX side
    rx_ok = rx_valid_i && (rxq.size() < DEPTH);
    rx_of = rx_valid_i && (rxq.size() == DEPTH);
    if (ss == 2'd2 && clr) begin
      rxq.delete(); rovf = 1'b0;
    end else begin
      if (ss == 2'd2 && stb && rxq.size() != 0) void'(rxq.pop_front());
      if (rx_ok) rxq.push_back(rx_data_i);
      if (rx_of) rovf = 1'b1;
    end
    m_psel = ss; m_p8 = sin[8]; m_p9 = sin[9];
  endtask

  task automatic compare_outputs();
    chk("mux_o", mux_o & exp_mask, exp_mux & exp_mask);
    chk("tx_valid", tx_valid_o, txq.size() != 0);
    if (txq.size() != 0) chk("tx_data", tx_data_o, txq[0]);
    chk("rx_ready", rx_ready_o, rxq.size() < DEPTH);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic do_reset(input int hold);
    resetn_i = 1'b0;
    #1;
    model_reset();
    compare_outputs();
    repeat (hold) step();
    resetn_i = 1'b1;
  endtask

  task automatic pulse(input int bitpos, input logic [7:0] d);
    mux_i[7:0] = d;
    mux_i[bitpos] = 1'b1;
    repeat (3) step();
    mux_i[bitpos] = 1'b0;
    repeat (3) step();
  endtask

  logic [7:0] eb [4];
  int         n;

  initial begin
    resetn_i = 1'b0; sel_i = '0; mux_i = 22'h2A5A5;
    tx_ready_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0; status_i = '0;
    eb = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset and loopback
    do_reset(3);
    repeat (4) step();
    chk("loopback", mux_o, 18'h2A5A5);
    mux_i = '0;

    // TX load with overflow, then core drain in order
    sel_i = 2'b01;
    repeat (4) step();
    pulse(8, 8'h11); pulse(8, 8'h22); pulse(8, 8'h33); pulse(8, 8'h44); pulse(8, 8'h55);
    chk("tx_full_ovf", mux_o, {12'b0, 1'b1, 1'b1, 1'b0, 3'd4});
    tx_ready_i = 1'b1;
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      if (tx_valid_o) begin
        chk("tx_order", tx_data_o, eb[n]);
        n++;
      end
      step();
    end
    chk("tx_drain_cnt", n, 4);
    chk("tx_drained", tx_valid_o, 1'b0);
    tx_ready_i = 1'b0;

    // Full TX FIFO: push coinciding with a core pop is accepted
    pulse(9, 8'h00);
    pulse(8, 8'hC0); pulse(8, 8'hC1); pulse(8, 8'hC2); pulse(8, 8'hC3);
    mux_i[7:0] = 8'hC4;
    mux_i[8] = 1'b1;
    step(); step();
    tx_ready_i = 1'b1;
    step();
    tx_ready_i = 1'b0;
    mux_i[8] = 1'b0;
    repeat (3) step();
    chk("tx_full_pop_push", mux_o, {12'b0, 1'b0, 1'b1, 1'b0, 3'd4});
    chk("tx_head_after", tx_data_o, 8'hC1);
    tx_ready_i = 1'b1;
    repeat (6) step();
    tx_ready_i = 1'b0;

    // RX read
    sel_i = 2'b10;
    repeat (4) step();
    rx_valid_i = 1'b1; rx_data_i = 8'hA1; step();
    rx_data_i = 8'hB2; step();
    rx_valid_i = 1'b0;
    repeat (3) step();
    chk("rx_two", mux_o, 18'h009A1);
    pulse(8, 8'h00);
    chk("rx_pop1", mux_o, 18'h005B2);
    pulse(8, 8'h00); pulse(8, 8'h00);
    chk("rx_empty", mux_o[17:8], 10'h000);

    // RX overflow and clear
    rx_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rx_data_i = 8'(i * 37 + 5);
      step();
    end
    chk("rx_full_ready", rx_ready_o, 1'b0);
    chk("rx_full_ovf", mux_o[17:8], 10'h013);
    rx_valid_i = 1'b0;
    pulse(9, 8'h00);
    chk("rx_cleared", mux_o[17:8], 10'h000);
    chk("rx_ready_clr", rx_ready_o, 1'b1);

    // Strobe held high across a mode change does not push
    sel_i = 2'b00;
    mux_i[8] = 1'b1;
    repeat (4) step();
    sel_i = 2'b01;
    repeat (6) step();
    chk("mode_chg_nopush", mux_o, {12'b0, 1'b0, 1'b0, 1'b1, 3'd0});
    mux_i[8] = 1'b0;
    repeat (3) step();

    // Reset mid-load
    pulse(8, 8'hD0); pulse(8, 8'hD1); pulse(8, 8'hD2);
    resetn_i = 1'b0;
    #1;
    chk("rst_mux", mux_o, 18'h0);
    chk("rst_txv", tx_valid_o, 1'b0);
    chk("rst_txd", tx_data_o, 8'h00);
    chk("rst_rxr", rx_ready_o, 1'b1);
    do_reset(2);
    repeat (6) step();
    chk("rst_tx_empty", mux_o, {12'b0, 1'b0, 1'b0, 1'b1, 3'd0});
    chk("rst_txv_after", tx_valid_o, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) sel_i = 2'($urandom);
      if ($urandom_range(0, 2) == 0) mux_i[8] = ~mux_i[8];
      if ($urandom_range(0, 29) == 0) mux_i[9] = ~mux_i[9];
      mux_i[7:0]   = 8'($urandom);
      mux_i[21:10] = 12'($urandom);
      tx_ready_i   = ($urandom_range(0, 3) == 0);
      rx_valid_i   = ($urandom_range(0, 2) == 0);
      rx_data_i    = 8'($urandom);
      status_i     = 16'($urandom);
      if ($urandom_range(0, 799) == 0) do_reset(2);
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
